// File: rtl/tetris_pkg.sv
// Shared constants for the move scheduler: FSM state codes, datapath move codes
// and the level-up row threshold.
package tetris_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] move_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ARB  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

  localparam move_t MOVE_ROTATE = 2'b00;
  localparam move_t MOVE_LEFT   = 2'b01;
  localparam move_t MOVE_RIGHT  = 2'b10;
  localparam move_t MOVE_DOWN   = 2'b11;

  localparam logic [3:0] ROWS_PER_LEVEL = 4'd10;
  localparam logic [3:0] LEVEL_MAX      = 4'd15;

endpackage

// File: rtl/gravity_timer.sv
// Gravity step timer: free-running up-counter that pulses tick once per period.
// With GRAVITY_LEVEL_EN defined the period shrinks by 1/16 per level, floored at GRAV_MIN.
module gravity_timer #(
  parameter logic [23:0] GRAV_PERIOD = 24'd6000000,
  parameter logic [23:0] GRAV_MIN    = 24'd500000
) (
  input  logic        clka,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  level,
  output logic        tick,
  output logic [23:0] period
);

  logic [23:0] cnt;

`ifdef GRAVITY_LEVEL_EN
  logic [23:0] dec;
  logic [23:0] scaled;

  // level <= 15, so dec never exceeds 15/16 of GRAV_PERIOD and cannot underflow
  assign dec    = {20'd0, level} * (GRAV_PERIOD >> 4);
  assign scaled = GRAV_PERIOD - dec;
  assign period = (scaled < GRAV_MIN) ? GRAV_MIN : scaled;
`else
  logic unused_level;

  assign unused_level = ^level;
  assign period       = GRAV_PERIOD;
`endif

  // >= rather than == keeps the wrap safe if the period shrinks below the count
  assign tick = en && (cnt >= (period - 24'd1));

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 24'd0;
    end else if (en) begin
      cnt <= tick ? 24'd0 : (cnt + 24'd1);
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Move scheduler: latches button/gravity requests, grants one at a time by fixed
// priority and handshakes each command with the datapath. Optional macro: GRAVITY_LEVEL_EN.
//
// state   | meaning
// IDLE    | game stopped, nothing pending
// ARB     | pick the highest-priority pending move
// WAIT    | cmd_valid held until cmd_done or timeout
module move_scheduler
  import tetris_pkg::*;
#(
  parameter logic [23:0] GRAV_PERIOD  = 24'd6000000,
  parameter logic [23:0] GRAV_MIN     = 24'd500000,
  parameter logic [7:0]  WAIT_TIMEOUT = 8'd64
) (
  input  logic       clka,
  input  logic       restart,
  input  logic       play_sig,
  input  logic       btn_left_en,
  input  logic       btn_right_en,
  input  logic       btn_rotate_en,
  input  logic       btn_down_en,
  input  logic       row_clear_pulse,
  input  logic       cmd_done,
  output logic       cmd_valid,
  output logic [1:0] cmd_move,
  output logic [3:0] level,
  output logic       timeout_err
);

  logic   rst_meta;
  logic   rst_n;
  state_t state;
  logic   pend_rot, pend_left, pend_right, pend_down, grav_pend;
  logic   any_pend;
  logic   do_grant;
  move_t  grant_code;
  logic   grav_tick;
  logic [23:0] grav_period;
  logic [7:0]  wait_cnt;
  logic [3:0]  row_cnt;

  // asynchronous assert, release aligned to clka
  always_ff @(posedge clka or negedge restart) begin
    if (!restart) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  gravity_timer #(
    .GRAV_PERIOD (GRAV_PERIOD),
    .GRAV_MIN    (GRAV_MIN)
  ) u_gravity (
    .clka   (clka),
    .rst_n  (rst_n),
    .en     (play_sig),
    .level  (level),
    .tick   (grav_tick),
    .period (grav_period)
  );

  assign any_pend = pend_rot | pend_left | pend_right | pend_down | grav_pend;
  assign do_grant = play_sig && (state == ST_ARB) && any_pend;

  always_comb begin
    grant_code = MOVE_DOWN;
    if (pend_rot)        grant_code = MOVE_ROTATE;
    else if (pend_left)  grant_code = MOVE_LEFT;
    else if (pend_right) grant_code = MOVE_RIGHT;
  end

  // a new pulse in the grant cycle wins over the clear
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      pend_rot   <= 1'b0;
      pend_left  <= 1'b0;
      pend_right <= 1'b0;
      pend_down  <= 1'b0;
      grav_pend  <= 1'b0;
    end else if (!play_sig) begin
      pend_rot   <= 1'b0;
      pend_left  <= 1'b0;
      pend_right <= 1'b0;
      pend_down  <= 1'b0;
      grav_pend  <= 1'b0;
    end else begin
      pend_rot   <= btn_rotate_en | (pend_rot   & ~(do_grant && grant_code == MOVE_ROTATE));
      pend_left  <= btn_left_en   | (pend_left  & ~(do_grant && grant_code == MOVE_LEFT));
      pend_right <= btn_right_en  | (pend_right & ~(do_grant && grant_code == MOVE_RIGHT));
      pend_down  <= btn_down_en   | (pend_down  & ~(do_grant && grant_code == MOVE_DOWN));
      grav_pend  <= grav_tick     | (grav_pend  & ~(do_grant && grant_code == MOVE_DOWN));
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cmd_valid   <= 1'b0;
      cmd_move    <= MOVE_ROTATE;
      wait_cnt    <= 8'd0;
      timeout_err <= 1'b0;
    end else if (!play_sig) begin
      state     <= ST_IDLE;
      cmd_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_ARB;
        ST_ARB: begin
          if (do_grant) begin
            cmd_move  <= grant_code;
            cmd_valid <= 1'b1;
            wait_cnt  <= WAIT_TIMEOUT - 8'd1;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cmd_done) begin
            cmd_valid <= 1'b0;
            state     <= ST_ARB;
          end else if (wait_cnt == 8'd0) begin
            cmd_valid   <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_ARB;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= 4'd0;
      level   <= 4'd0;
    end else if (row_clear_pulse) begin
      if (row_cnt == (ROWS_PER_LEVEL - 4'd1)) begin
        row_cnt <= 4'd0;
        if (level != LEVEL_MAX) level <= level + 4'd1;
      end else begin
        row_cnt <= row_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: cycle model of the scheduling rules,
// a datapath responder, directed scenarios and a randomized soak.
module tb_move_scheduler;
  import tetris_pkg::*;

  localparam logic [23:0] GP = 24'd16;
  localparam logic [23:0] GM = 24'd4;
  localparam logic [7:0]  WT = 8'd8;

  logic clka = 1'b0;
  logic restart = 1'b0, play_sig = 1'b0;
  logic btn_left_en = 1'b0, btn_right_en = 1'b0, btn_rotate_en = 1'b0, btn_down_en = 1'b0;
  logic row_clear_pulse = 1'b0, cmd_done = 1'b0;
  logic cmd_valid, timeout_err;
  logic [1:0] cmd_move;
  logic [3:0] level;

  move_scheduler #(.GRAV_PERIOD(GP), .GRAV_MIN(GM), .WAIT_TIMEOUT(WT)) dut (
    .clka(clka), .restart(restart), .play_sig(play_sig),
    .btn_left_en(btn_left_en), .btn_right_en(btn_right_en),
    .btn_rotate_en(btn_rotate_en), .btn_down_en(btn_down_en),
    .row_clear_pulse(row_clear_pulse), .cmd_done(cmd_done),
    .cmd_valid(cmd_valid), .cmd_move(cmd_move), .level(level), .timeout_err(timeout_err)
  );

  always #5 clka = ~clka;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int period_of(input int lvl);
    int p;
`ifdef GRAVITY_LEVEL_EN
    p = int'(GP) - lvl * (int'(GP) / 16);
    if (p < int'(GM)) p = int'(GM);
`else
    p = int'(GP);
`endif
    return p;
  endfunction

  // ---------------- reference model ----------------
  bit m_run, m_busy, m_valid, m_terr, m_gpend;
  bit m_pend[4];
  int m_cmd, m_gcnt, m_rows, m_level, m_cyc, m_gcyc;

  task automatic model_reset();
    m_run = 0; m_busy = 0; m_valid = 0; m_terr = 0; m_gpend = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
    m_cmd = 0; m_gcnt = 0; m_rows = 0; m_level = 0; m_cyc = 0; m_gcyc = 0;
  endtask

  task automatic model_step();
    bit b[4];
    int per, g;
    bit tick;
    b = '{btn_rotate_en, btn_left_en, btn_right_en, btn_down_en};
    per = period_of(m_level);
    g = -1;
    m_cyc++;
    if (row_clear_pulse) begin
      if (m_rows == 9) begin
        m_rows = 0;
        if (m_level < 15) m_level++;
      end else m_rows++;
    end
    if (!play_sig) begin
      m_run = 0; m_busy = 0; m_valid = 0; m_gpend = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      tick = (m_gcnt >= per - 1);
      m_gcnt = tick ? 0 : m_gcnt + 1;
      if (!m_run) m_run = 1;
      else if (m_busy) begin
        if (cmd_done) begin m_busy = 0; m_valid = 0; end
        else if (m_cyc - m_gcyc == int'(WT)) begin m_terr = 1; m_busy = 0; m_valid = 0; end
      end else if (m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3] | m_gpend) begin
        g = m_pend[0] ? 0 : m_pend[1] ? 1 : m_pend[2] ? 2 : 3;
        m_busy = 1; m_valid = 1; m_cmd = g; m_gcyc = m_cyc;
      end
      for (int i = 0; i < 4; i++) m_pend[i] = b[i] | (m_pend[i] && g != i);
      m_gpend = tick | (m_gpend && g != 3);
    end
  endtask

  always @(posedge clka or negedge restart) begin
    if (!restart) model_reset();
    else model_step();
  end

  // ---------------- compare process ----------------
  always @(negedge clka) begin
    chk("cmd_valid", cmd_valid, m_valid);
    chk("cmd_move", cmd_move, m_cmd);
    chk("level", level, m_level);
    chk("timeout_err", timeout_err, m_terr);
    chk("period", dut.u_gravity.period, period_of(m_level));
  end

  // ---------------- datapath responder / command monitor ----------------
  int tb_cyc = 0, hi = 0, done_delay = 2;
  bit prev_v = 0, withhold = 0, spur_en = 0, rand_delays = 0;
  int log_mv[$], log_cy[$], len_q[$];

  always @(negedge clka) begin
    tb_cyc++;
    if (cmd_valid && !prev_v) begin log_mv.push_back(cmd_move); log_cy.push_back(tb_cyc); end
    if (!cmd_valid && prev_v) len_q.push_back(hi);
    hi = cmd_valid ? hi + 1 : 0;
    if (rand_delays && cmd_valid && hi == 1) begin
      done_delay = $urandom_range(1, 10);
      withhold = ($urandom_range(0, 9) == 0);
    end
    cmd_done = (cmd_valid && !withhold && hi == done_delay) ||
               (spur_en && !cmd_valid && $urandom_range(0, 7) == 0);
    prev_v = cmd_valid;
  end

  task automatic step();
    @(negedge clka);
    #1;
  endtask

  initial begin
    int k, exp_p;
    repeat (3) step();
    restart = 1'b1;
    repeat (4) step();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_state", dut.state, ST_IDLE);

    // rotate and left together: rotate first, then left
    play_sig = 1'b1; btn_left_en = 1'b1; btn_rotate_en = 1'b1;
    step();
    btn_left_en = 1'b0; btn_rotate_en = 1'b0;
    k = 0;
    while (log_mv.size() < 2 && k < 40) begin step(); k++; end
    chk("prio_two_cmds_seen", log_mv.size() >= 2, 1);
    if (log_mv.size() >= 2) begin
      chk("prio_first_rotate", log_mv[0], 0);
      chk("prio_second_left", log_mv[1], 1);
    end

    // gravity only: a down command every 16 cycles
    log_mv.delete(); log_cy.delete();
    k = 0;
    while (log_mv.size() < 4 && k < 100) begin step(); k++; end
    chk("grav_four_cmds_seen", log_mv.size() >= 4, 1);
    if (log_mv.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("grav_move_down", log_mv[i], 3);
      for (int i = 1; i < 4; i++) chk("grav_interval", log_cy[i] - log_cy[i-1], 16);
    end

    // down button coinciding with gravity tick: one down command
    k = 0;
    while (m_gcnt != period_of(m_level) - 1 && k < 20) begin step(); k++; end
    chk("align_to_tick", m_gcnt, period_of(m_level) - 1);
    log_mv.delete(); log_cy.delete();
    btn_down_en = 1'b1;
    step();
    btn_down_en = 1'b0;
    repeat (13) step();
    chk("merge_down_count", log_mv.size(), 1);
    if (log_mv.size() >= 1) chk("merge_down_move", log_mv[0], 3);

    // withheld cmd_done: times out after 8 cycles
    withhold = 1'b1;
    len_q.delete();
    btn_rotate_en = 1'b1;
    step();
    btn_rotate_en = 1'b0;
    k = 0;
    while (len_q.size() < 1 && k < 30) begin step(); k++; end
    chk("timeout_seen", len_q.size() >= 1, 1);
    if (len_q.size() >= 1) chk("timeout_valid_len", len_q[0], 8);
    chk("timeout_err_set", timeout_err, 1);
    withhold = 1'b0;
    repeat (20) step();

    // 30 cleared rows -> level 3
    for (int i = 0; i < 30; i++) begin
      row_clear_pulse = 1'b1; step();
      row_clear_pulse = 1'b0; step();
    end
    chk("level_after_30_rows", level, 3);
`ifdef GRAVITY_LEVEL_EN
    exp_p = 13;
`else
    exp_p = 16;
`endif
    chk("period_at_level3", dut.u_gravity.period, exp_p);

    // randomized soak
    spur_en = 1'b1; rand_delays = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      play_sig        = ($urandom_range(0, 99) != 0);
      btn_rotate_en   = ($urandom_range(0, 7) == 0);
      btn_left_en     = ($urandom_range(0, 7) == 0);
      btn_right_en    = ($urandom_range(0, 7) == 0);
      btn_down_en     = ($urandom_range(0, 7) == 0);
      row_clear_pulse = ($urandom_range(0, 9) == 0);
      step();
    end
    spur_en = 1'b0; rand_delays = 1'b0; withhold = 1'b0; done_delay = 2;
    play_sig = 1'b1;
    btn_rotate_en = 1'b0; btn_left_en = 1'b0; btn_right_en = 1'b0; btn_down_en = 1'b0;
    for (int i = 0; i < 150; i++) begin
      row_clear_pulse = 1'b1; step();
      row_clear_pulse = 1'b0; step();
    end
    chk("level_saturated", level, 15);
`ifdef GRAVITY_LEVEL_EN
    exp_p = 4;
`else
    exp_p = 16;
`endif
    chk("period_at_level15", dut.u_gravity.period, exp_p);

    // reset in the middle of WAIT
    repeat (20) step();
    withhold = 1'b1;
    btn_rotate_en = 1'b1;
    step();
    btn_rotate_en = 1'b0;
    k = 0;
    while (!cmd_valid && k < 10) begin step(); k++; end
    chk("midwait_valid_seen", cmd_valid, 1);
    step(); step();
    restart = 1'b0;
    step();
    chk("midwait_rst_valid", cmd_valid, 0);
    chk("midwait_rst_level", level, 0);
    chk("midwait_rst_state", dut.state, ST_IDLE);
    chk("midwait_rst_terr", timeout_err, 0);
    play_sig = 1'b0;
    withhold = 1'b0;
    step();
    restart = 1'b1;
    repeat (6) step();
    chk("post_rst_valid", cmd_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
